// File: rtl/dados_ram_param.sv
// Load/store data memory: byte/half/word access with byte-lane writes,
// sign/zero-extended loads through a registered read port, alignment
// rejection, and a power-up sequencer that zeroes every word before the
// first request is accepted.
module dados_ram_param #(
  parameter int DEPTH  = 1024,  // number of 32-bit words, power of two, >= 2
  parameter int ADDR_W = 32     // byte address width
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] endereco,
  input  logic [31:0]       dados,
  input  logic              escreve_mem,
  input  logic              le_mem,
  input  logic [1:0]        tamanho,
  input  logic              sem_sinal,
  output logic              pronto,
  output logic [31:0]       dados_lidos,
  output logic              valido,
  output logic              erro_alinhamento
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {LIMPANDO, ATIVO} estado_t;

  estado_t         estado_q, estado_d;
  logic [AW-1:0]   cont_q, cont_d;
  logic            limpando;

  logic [AW-1:0]   idx;
  logic [1:0]      lane;
  logic            aceito;
  logic            legal;
  logic            store_ok;
  logic            load_ok;
  logic            erro_d;

  logic [3:0]      be;
  logic [31:0]     wdata_rep;
  logic [3:0]      lane_we;
  logic [31:0]     lane_wdata;
  logic [AW-1:0]   waddr;
  logic [31:0]     rdata;

  logic            valido_q;
  logic            erro_q;
  logic            carregado_q;
  logic [1:0]      lane_q;
  logic [1:0]      tam_q;
  logic            sem_q;

  assign idx  = endereco[AW+1:2];
  assign lane = endereco[1:0];

  // Upper address bits are deliberately ignored: the array wraps.
  if (ADDR_W > AW + 2) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^endereco[ADDR_W-1:AW+2];
  end

  // State and clear-counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= LIMPANDO;
      cont_q   <= '0;
    end else begin
      estado_q <= estado_d;
      cont_q   <= cont_d;
    end
  end

  // Clear sequencer: walk every word once, then accept requests until reset.
  always_comb begin
    estado_d = estado_q;
    cont_d   = cont_q;
    limpando = 1'b0;
    case (estado_q)
      LIMPANDO: begin
        limpando = 1'b1;
        cont_d   = cont_q + 1'b1;
        if (cont_q == AW'(DEPTH - 1)) estado_d = ATIVO;
      end
      default: ;
    endcase
  end

  assign pronto = (estado_q == ATIVO);
  assign aceito = pronto && (escreve_mem || le_mem);

  // Alignment rule per access size; size code 11 is never legal.
  always_comb begin
    legal = 1'b0;
    case (tamanho)
      2'b00:   legal = 1'b1;
      2'b01:   legal = ~endereco[0];
      2'b10:   legal = (endereco[1:0] == 2'b00);
      default: legal = 1'b0;
    endcase
  end

  // A simultaneous store+load performs only the store.
  assign store_ok = aceito && legal && escreve_mem;
  assign load_ok  = aceito && legal && le_mem && !escreve_mem;
  assign erro_d   = aceito && !legal;

  // Lane enables and right-aligned store data replicated across lanes.
  always_comb begin
    be        = 4'b0000;
    wdata_rep = dados;
    case (tamanho)
      2'b00: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{dados[7:0]}};
      end
      2'b01: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{dados[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = dados;
      end
    endcase
  end

  // Single write port shared by the clear sequencer and stores.
  always_comb begin
    lane_we    = store_ok ? be : 4'b0000;
    lane_wdata = wdata_rep;
    waddr      = idx;
    if (limpando) begin
      lane_we    = 4'b1111;
      lane_wdata = '0;
      waddr      = cont_q;
    end
  end

  // One byte-wide array per lane so each maps to its own inferred RAM.
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_q;

    // Lane write and registered read.
    always_ff @(posedge clock) begin
      if (lane_we[gi]) mem_q[waddr] <= lane_wdata[gi*8 +: 8];
      if (load_ok)     rd_q         <= mem_q[idx];
    end

    assign rdata[gi*8 +: 8] = rd_q;
  end

  // Strobes and the access attributes needed to shape the registered word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valido_q    <= 1'b0;
      erro_q      <= 1'b0;
      carregado_q <= 1'b0;
      lane_q      <= 2'b00;
      tam_q       <= 2'b00;
      sem_q       <= 1'b0;
    end else begin
      valido_q <= load_ok;
      erro_q   <= erro_d;
      if (load_ok) begin
        carregado_q <= 1'b1;
        lane_q      <= lane;
        tam_q       <= tamanho;
        sem_q       <= sem_sinal;
      end
    end
  end

  // Extract and extend from the read register; zero until a load lands
  // after reset since the RAM read registers themselves are not reset.
  always_comb begin
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    sel_b = rdata[lane_q*8 +: 8];
    sel_h = lane_q[1] ? rdata[31:16] : rdata[15:0];
    case (tam_q)
      2'b00:   dados_lidos = sem_q ? {24'b0, sel_b} : {{24{sel_b[7]}}, sel_b};
      2'b01:   dados_lidos = sem_q ? {16'b0, sel_h} : {{16{sel_h[15]}}, sel_h};
      default: dados_lidos = rdata;
    endcase
    if (!carregado_q) dados_lidos = '0;
  end

  assign valido           = valido_q;
  assign erro_alinhamento = erro_q;

endmodule

// File: tb/tb_dados_ram_param.sv
// Directed bench for dados_ram_param with DEPTH=16 (64 bytes of address space).
module tb_dados_ram_param;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 32;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [ADDR_W-1:0] endereco;
  logic [31:0]       dados;
  logic              escreve_mem;
  logic              le_mem;
  logic [1:0]        tamanho;
  logic              sem_sinal;
  logic              pronto;
  logic [31:0]       dados_lidos;
  logic              valido;
  logic              erro_alinhamento;

  int errors = 0;
  int checks = 0;

  dados_ram_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .endereco         (endereco),
    .dados            (dados),
    .escreve_mem      (escreve_mem),
    .le_mem           (le_mem),
    .tamanho          (tamanho),
    .sem_sinal        (sem_sinal),
    .pronto           (pronto),
    .dados_lidos      (dados_lidos),
    .valido           (valido),
    .erro_alinhamento (erro_alinhamento)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [1:0]  tam;
    logic        sem;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_v;
    logic        exp_e;
  } vec_t;

  vec_t vecs[25];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    escreve_mem = 1'b0;
    le_mem      = 1'b0;
    tamanho     = 2'b10;
    sem_sinal   = 1'b0;
    endereco    = '0;
    dados       = '0;
  endtask

  // Drive one request, let one edge take it, then check all result outputs.
  task automatic apply(input vec_t v);
    escreve_mem = v.we;
    le_mem      = v.re;
    tamanho     = v.tam;
    sem_sinal   = v.sem;
    endereco    = v.addr;
    dados       = v.data;
    @(posedge clock); #1;
    $display("op %s addr=%h rd=%h v=%b e=%b", v.name, v.addr, dados_lidos, valido, erro_alinhamento);
    chk({v.name, ".rd"}, dados_lidos, v.exp_rd);
    chk({v.name, ".valido"}, {31'b0, valido}, {31'b0, v.exp_v});
    chk({v.name, ".erro"}, {31'b0, erro_alinhamento}, {31'b0, v.exp_e});
  endtask

  // Clear takes exactly DEPTH edges; requests present meanwhile must be ignored.
  task automatic check_clear(input string tag);
    for (int k = 1; k <= DEPTH; k++) begin
      @(posedge clock); #1;
      chk($sformatf("%s.pronto@%0d", tag, k), {31'b0, pronto}, {31'b0, (k == DEPTH)});
      chk($sformatf("%s.valido@%0d", tag, k), {31'b0, valido}, 32'd0);
      chk($sformatf("%s.erro@%0d", tag, k), {31'b0, erro_alinhamento}, 32'd0);
    end
    $display("clear %s done pronto=%b", tag, pronto);
  endtask

  function automatic vec_t mk(input string n, input logic we, input logic re,
                              input logic [1:0] tam, input logic sem,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_rd, input logic exp_v,
                              input logic exp_e);
    vec_t v;
    v.name = n; v.we = we; v.re = re; v.tam = tam; v.sem = sem;
    v.addr = addr; v.data = data; v.exp_rd = exp_rd; v.exp_v = exp_v; v.exp_e = exp_e;
    return v;
  endfunction

  initial begin
    //            name        we  re  tam    sem   addr   data           exp_rd         v  e
    vecs[0]  = mk("stW10",    1, 0, 2'b10, 0, 32'h10, 32'h8081_7F01, 32'h0000_0000, 0, 0);
    vecs[1]  = mk("ldB13s",   0, 1, 2'b00, 0, 32'h13, 32'h0,         32'hFFFF_FF80, 1, 0);
    vecs[2]  = mk("ldB13u",   0, 1, 2'b00, 1, 32'h13, 32'h0,         32'h0000_0080, 1, 0);
    vecs[3]  = mk("ldH12s",   0, 1, 2'b01, 0, 32'h12, 32'h0,         32'hFFFF_8081, 1, 0);
    vecs[4]  = mk("ldB10",    0, 1, 2'b00, 0, 32'h10, 32'h0,         32'h0000_0001, 1, 0);
    vecs[5]  = mk("stW20",    1, 0, 2'b10, 0, 32'h20, 32'h1122_3344, 32'h0000_0001, 0, 0);
    vecs[6]  = mk("stB21",    1, 0, 2'b00, 0, 32'h21, 32'hFFFF_FFAA, 32'h0000_0001, 0, 0);
    vecs[7]  = mk("ldW20",    0, 1, 2'b10, 0, 32'h20, 32'h0,         32'h1122_AA44, 1, 0);
    vecs[8]  = mk("badLdH03", 0, 1, 2'b01, 0, 32'h03, 32'h0,         32'h1122_AA44, 0, 1);
    vecs[9]  = mk("badStW02", 1, 0, 2'b10, 0, 32'h02, 32'hFFFF_FFFF, 32'h1122_AA44, 0, 1);
    vecs[10] = mk("badLdT3",  0, 1, 2'b11, 0, 32'h20, 32'h0,         32'h1122_AA44, 0, 1);
    vecs[11] = mk("badStT3",  1, 0, 2'b11, 0, 32'h20, 32'h0,         32'h1122_AA44, 0, 1);
    vecs[12] = mk("ldW00",    0, 1, 2'b10, 0, 32'h00, 32'h0,         32'h0000_0000, 1, 0);
    vecs[13] = mk("ldW20b",   0, 1, 2'b10, 0, 32'h20, 32'h0,         32'h1122_AA44, 1, 0);
    vecs[14] = mk("ldH22u",   0, 1, 2'b01, 1, 32'h22, 32'h0,         32'h0000_1122, 1, 0);
    vecs[15] = mk("ldH20s",   0, 1, 2'b01, 0, 32'h20, 32'h0,         32'hFFFF_AA44, 1, 0);
    vecs[16] = mk("stW40",    1, 0, 2'b10, 0, 32'h40, 32'hDEAD_BEEF, 32'hFFFF_AA44, 0, 0);
    vecs[17] = mk("ldW40raw", 0, 1, 2'b10, 0, 32'h40, 32'h0,         32'hDEAD_BEEF, 1, 0);
    vecs[18] = mk("ldW00wrap",0, 1, 2'b10, 1, 32'h00, 32'h0,         32'hDEAD_BEEF, 1, 0);
    vecs[19] = mk("stLdW24",  1, 1, 2'b10, 0, 32'h24, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0);
    vecs[20] = mk("ldW24",    0, 1, 2'b10, 0, 32'h24, 32'h0,         32'hCAFE_F00D, 1, 0);
    vecs[21] = mk("stH26",    1, 0, 2'b01, 0, 32'h26, 32'hABCD_1234, 32'hCAFE_F00D, 0, 0);
    vecs[22] = mk("ldW24b",   0, 1, 2'b10, 0, 32'h24, 32'h0,         32'h1234_F00D, 1, 0);
    vecs[23] = mk("ldB27u",   0, 1, 2'b00, 1, 32'h27, 32'h0,         32'h0000_0012, 1, 0);
    vecs[24] = mk("idle",     0, 0, 2'b10, 0, 32'h00, 32'h0,         32'h0000_0012, 0, 0);

    // Reset state while reset_n is held low.
    idle();
    reset_n = 1'b0;
    #2;
    chk("rst.pronto", {31'b0, pronto}, 32'd0);
    chk("rst.rd", dados_lidos, 32'd0);
    chk("rst.valido", {31'b0, valido}, 32'd0);
    chk("rst.erro", {31'b0, erro_alinhamento}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    check_clear("clr1");

    // Every word reads back zero, valido on consecutive cycles.
    for (int i = 0; i < DEPTH; i++)
      apply(mk($sformatf("zero%0d", i), 0, 1, 2'b10, 0, 32'(i * 4), 32'h0, 32'h0, 1, 0));

    for (int i = 0; i < 25; i++) apply(vecs[i]);

    // Load accepted, then reset asserted right after: outputs clear at once.
    apply(mk("preRst", 0, 1, 2'b10, 0, 32'h24, 32'h0, 32'h1234_F00D, 1, 0));
    le_mem = 1'b1; tamanho = 2'b10; endereco = 32'h24;
    #2;
    reset_n = 1'b0;
    #1;
    chk("midLoad.rd", dados_lidos, 32'd0);
    chk("midLoad.valido", {31'b0, valido}, 32'd0);
    chk("midLoad.pronto", {31'b0, pronto}, 32'd0);
    @(posedge clock); #1;
    chk("midLoad.valido2", {31'b0, valido}, 32'd0);
    chk("midLoad.rd2", dados_lidos, 32'd0);
    // Requests stay active through the clear and must be ignored.
    escreve_mem = 1'b1; le_mem = 1'b1; endereco = 32'h0C; dados = 32'h5555_5555;
    reset_n = 1'b1;
    check_clear("clr2");
    idle();
    apply(mk("ignW0C", 0, 1, 2'b10, 0, 32'h0C, 32'h0, 32'h0000_0000, 1, 0));
    apply(mk("clrW24", 0, 1, 2'b10, 0, 32'h24, 32'h0, 32'h0000_0000, 1, 0));
    apply(mk("stW30", 1, 0, 2'b10, 0, 32'h30, 32'h5A5A_5A5A, 32'h0000_0000, 0, 0));
    apply(mk("ldW30", 0, 1, 2'b10, 0, 32'h30, 32'h0, 32'h5A5A_5A5A, 1, 0));

    // Reset pulse part-way through a clear restarts it at word 0.
    reset_n = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clock); #1;
    end
    chk("midClr.pronto", {31'b0, pronto}, 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midClr.rstPronto", {31'b0, pronto}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    check_clear("clr3");
    apply(mk("clrW30", 0, 1, 2'b10, 0, 32'h30, 32'h0, 32'h0000_0000, 1, 0));
    apply(mk("clrW10", 0, 1, 2'b10, 0, 32'h10, 32'h0, 32'h0000_0000, 1, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
